// File: rtl/logic_unit_if.sv
// logic_unit_if: operand/result handshake bundle between a source and the logic unit.
interface logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ones;
    logic             parity;
    logic [CNT_W-1:0] op_count;
    modport master (
        output in_valid, a, b, op, acc_en, acc_clr, out_ready,
        input  in_ready, out_valid, result, zero, ones, parity, op_count
    );
    modport slave (
        input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
        output in_ready, out_valid, result, zero, ones, parity, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with accumulator, status flags and saturating op count.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst,
    logic_unit_if.slave io
);
    logic             accept, in_ready;
    logic [WIDTH-1:0] op_a, res;
    logic             out_valid_d, out_valid_q;
    logic [WIDTH-1:0] result_d, result_q, acc_d, acc_q;
    logic             zero_d, zero_q, ones_d, ones_q, parity_d, parity_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    always_comb begin
        in_ready    = ~out_valid_q | io.out_ready;
        accept      = io.in_valid & in_ready;
        op_a        = io.acc_en ? (io.acc_clr ? '0 : acc_q) : io.a;
        res         = '0;
        case (io.op)
            3'd0: res = ~(op_a & io.b);
            3'd1: res = op_a & io.b;
            3'd2: res = op_a | io.b;
            3'd3: res = op_a ^ io.b;
            3'd4: res = ~(op_a | io.b);
            3'd5: res = ~(op_a ^ io.b);
            3'd6: res = ~op_a;
            default: res = op_a & ~io.b;
        endcase
        out_valid_d = accept | (out_valid_q & ~io.out_ready);
        result_d    = accept ? res : result_q;
        // flags come from the same combinational result that is captured
        zero_d      = accept ? (res == '0) : zero_q;
        ones_d      = accept ? (res == '1) : ones_q;
        parity_d    = accept ? ^res : parity_q;
        acc_d       = (accept & io.acc_en) ? res : io.acc_clr ? '0 : acc_q;
        cnt_d       = (accept && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            ones_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end
    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.zero      = zero_q;
    assign io.ones      = ones_q;
    assign io.parity    = parity_q;
    assign io.op_count  = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed and randomized checks of logic_unit_pipe against a behavioural model.
module tb_logic_unit_pipe;
    localparam int W = 8;
    localparam int C = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    logic_unit_if #(.WIDTH(W), .CNT_W(C)) io ();
    logic_unit_pipe #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst(rst), .io(io));
    int n_checks = 0;
    int n_fail = 0;
    logic       m_valid;
    logic [7:0] m_res, m_acc;
    int         m_cnt;
    function automatic logic [7:0] lu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd0: return ~(x & y);
            3'd1: return x & y;
            3'd2: return x | y;
            3'd3: return x ^ y;
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return ~x;
            default: return x & ~y;
        endcase
    endfunction
    function automatic logic [15:0] expv();
        logic [3:0] c = m_cnt[3:0];
        return {m_valid, m_res, m_res == 8'h00, m_res == 8'hFF, ^m_res, c};
    endfunction
    function automatic logic [15:0] dutv();
        return {io.out_valid, io.result, io.zero, io.ones, io.parity, io.op_count};
    endfunction
    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic en, input logic clr, input logic ordy);
        io.in_valid = v; io.a = a; io.b = b; io.op = op;
        io.acc_en = en; io.acc_clr = clr; io.out_ready = ordy;
    endtask
    task automatic model_reset();
        m_valid = 1'b0; m_res = 8'h00; m_acc = 8'h00; m_cnt = 0;
    endtask
    task automatic clock();
        logic       acc_ok;
        logic [7:0] aa, r;
        acc_ok = io.in_valid && (!m_valid || io.out_ready);
        aa = io.acc_en ? (io.acc_clr ? 8'h00 : m_acc) : io.a;
        r = lu(io.op, aa, io.b);
        @(posedge clk); #1;
        if (acc_ok) begin
            m_res = r; m_valid = 1'b1;
            if (m_cnt < 15) m_cnt++;
        end else if (io.out_ready) m_valid = 1'b0;
        if (acc_ok && io.acc_en) m_acc = r;
        else if (io.acc_clr) m_acc = 8'h00;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        do_reset();
        n_checks++;
        if (dutv() !== 16'h0040 || io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset: got %h rdy %b, want 0040 rdy 1", dutv(), io.in_ready);
        end
    endtask
    task automatic test_op_sweep();
        logic [7:0] tbl [8] = '{8'h7E, 8'h81, 8'hE7, 8'h66, 8'h18, 8'h99, 8'h3C, 8'h42};
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'hC3, 8'hA5, 3'(i), 0, 0, 1);
            clock();
            n_checks++;
            if (io.result !== tbl[i] || io.zero !== 1'b0 || io.out_valid !== 1'b1 || dutv() !== expv()) begin
                n_fail++; $display("FAIL op_sweep op=%0d: got %h z %b, want %h", i, io.result, io.zero, tbl[i]);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        clock();
    endtask
    task automatic test_stall();
        drive(1, 8'hF0, 8'h0F, 3, 0, 0, 0);
        clock();
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'h12, 8'h34, 1, 0, 0, 0);
            clock();
            n_checks++;
            if (io.result !== 8'hFF || io.ones !== 1'b1 || io.out_valid !== 1'b1 || io.in_ready !== 1'b0
                || dutv() !== expv()) begin
                n_fail++; $display("FAIL stall cyc %0d: got res %h ones %b ov %b rdy %b, want FF 1 1 0",
                                   i, io.result, io.ones, io.out_valid, io.in_ready);
            end
        end
        drive(1, 8'h12, 8'h34, 1, 0, 0, 1);
        #1;
        n_checks++;
        if (io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL stall_release in_ready: got %b, want 1", io.in_ready);
        end
        clock();
        n_checks++;
        if (io.result !== 8'h10 || io.out_valid !== 1'b1 || dutv() !== expv()) begin
            n_fail++; $display("FAIL back_to_back: got res %h ov %b, want 10 1", io.result, io.out_valid);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        clock();
    endtask
    task automatic test_accumulate();
        logic [7:0] bs [4] = '{8'h01, 8'h02, 8'h04, 8'h07};
        logic [7:0] ex [4] = '{8'h01, 8'h03, 8'h07, 8'h00};
        drive(0, 0, 0, 0, 0, 1, 1);
        clock();
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hFF, bs[i], (i == 3) ? 3'd3 : 3'd2, 1, 0, 1);
            clock();
            n_checks++;
            if (io.result !== ex[i] || io.zero !== (i == 3) || dutv() !== expv()) begin
                n_fail++; $display("FAIL accumulate step %0d: got %h z %b, want %h", i, io.result, io.zero, ex[i]);
            end
        end
    endtask
    task automatic test_clear_accept();
        drive(1, 8'h00, 8'h3C, 2, 1, 1, 1);
        clock();
        drive(1, 8'h00, 8'h11, 2, 1, 1, 1);
        clock();
        n_checks++;
        if (io.result !== 8'h11 || dutv() !== expv()) begin
            n_fail++; $display("FAIL clear_accept: got %h, want 11", io.result);
        end
        drive(1, 8'hAA, 8'h00, 2, 1, 0, 1);
        clock();
        n_checks++;
        if (io.result !== 8'h11 || dutv() !== expv()) begin
            n_fail++; $display("FAIL clear_accept acc: got %h, want 11", io.result);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        clock();
    endtask
    task automatic test_saturation();
        drive(0, 0, 0, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i == 19) drive(1, 8'h07, 8'h07, 1, 0, 0, 1);
            else drive(1, 8'($urandom), 8'($urandom), 3'($urandom), 0, 0, 1);
            clock();
            n_checks++;
            if (io.op_count !== 4'((i < 15) ? i + 1 : 15) || dutv() !== expv()) begin
                n_fail++; $display("FAIL saturation %0d: got cnt %0d, want %0d", i, io.op_count, (i < 15) ? i + 1 : 15);
            end
        end
        n_checks++;
        if (io.result !== 8'h07 || io.parity !== 1'b1) begin
            n_fail++; $display("FAIL parity07: got res %h par %b, want 07 1", io.result, io.parity);
        end
    endtask
    task automatic test_async_reset();
        drive(1, 8'h5A, 8'h0F, 2, 0, 0, 0);
        clock();
        drive(0, 0, 0, 0, 0, 0, 0);
        clock();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (dutv() !== 16'h0040 || io.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: got %h rdy %b, want 0040 rdy 1", dutv(), io.in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
            #1;
            n_checks++;
            if (io.in_ready !== (!m_valid || io.out_ready)) begin
                n_fail++; $display("FAIL random in_ready %0d: got %b, want %b", i, io.in_ready, !m_valid || io.out_ready);
            end
            clock();
            n_checks++;
            if (dutv() !== expv()) begin
                n_fail++; $display("FAIL random %0d: got %h, want %h", i, dutv(), expv());
            end
        end
    endtask
    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_op_sweep();
        test_stall();
        test_accumulate();
        test_clear_accept();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
